// File: rtl/y86_stage_sequencer.sv
// y86_stage_sequencer: multi-cycle fetch/decode/execute/memory/writeback/PC control FSM for the Y86 datapath
// Ports: CLK/RST (sync active-high) | icode from decode | imem_/dmem_ ready+error handshake inputs
//        imem_req/dmem_req requests | f/d/e/m/w/pc_en one-cycle stage enables
//        stat (0 AOK,1 HLT,2 ADR,3 INS), halted | cycle_cnt, retired_cnt free-running counters
module y86_stage_sequencer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_WID     = 32
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [3:0]         icode,
    input  logic               imem_ready,
    input  logic               imem_error,
    input  logic               dmem_ready,
    input  logic               dmem_error,
    output logic               imem_req,
    output logic               dmem_req,
    output logic               f_en,
    output logic               d_en,
    output logic               e_en,
    output logic               m_en,
    output logic               w_en,
    output logic               pc_en,
    output logic [1:0]         stat,
    output logic               halted,
    output logic [CNT_WID-1:0] cycle_cnt,
    output logic [CNT_WID-1:0] retired_cnt
);
    localparam int TW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [1:0] AOK = 2'd0, HLT = 2'd1, ADR = 2'd2, INS = 2'd3;
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_PC, S_HALT} state_t;
    state_t state, next_state;
    logic [1:0] next_stat;
    logic [TW-1:0] tmo;
    logic mem_st, rdy, err, fault, retire;
    always_comb begin
        mem_st = state == S_FETCH || state == S_MEM;
        rdy = state == S_FETCH ? imem_ready : dmem_ready;
        err = state == S_FETCH ? imem_error : dmem_error;
        fault = mem_st && (rdy ? err : tmo == TW'(MEM_TIMEOUT - 1));
        next_state = state;
        next_stat = stat;
        retire = 1'b0;
        {imem_req, dmem_req, f_en, d_en, e_en, m_en, w_en, pc_en} = '0;
        halted = state == S_HALT;
        case (state)
            S_FETCH: begin
                imem_req = 1'b1;
                f_en = imem_ready && !imem_error;
                next_state = f_en ? S_DECODE : fault ? S_HALT : S_FETCH;
            end
            S_DECODE: begin
                d_en = 1'b1;
                retire = icode == 4'h0;
                next_state = (icode == 4'h0 || icode > 4'hB) ? S_HALT : S_EXEC;
                next_stat = icode == 4'h0 ? HLT : icode > 4'hB ? INS : stat;
            end
            S_EXEC: begin
                e_en = 1'b1;
                next_state = icode inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB} ? S_MEM :
                             icode inside {4'h2, 4'h3, 4'h6} ? S_WB : S_PC;
            end
            S_MEM: begin
                dmem_req = 1'b1;
                m_en = dmem_ready && !dmem_error;
                next_state = m_en ? (icode == 4'h4 ? S_PC : S_WB) : fault ? S_HALT : S_MEM;
            end
            S_WB: begin
                w_en = 1'b1;
                next_state = S_PC;
            end
            S_PC: begin
                pc_en = 1'b1;
                retire = 1'b1;
                next_state = S_FETCH;
            end
            S_HALT: next_state = S_HALT;
            default: next_state = S_FETCH;
        endcase
        next_stat = fault ? ADR : next_stat;
        if (RST) {imem_req, dmem_req, f_en, d_en, e_en, m_en, w_en, pc_en} = '0;
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_FETCH;
            stat <= AOK;
            tmo <= '0;
            cycle_cnt <= '0;
            retired_cnt <= '0;
        end else begin
            state <= next_state;
            stat <= next_stat;
            tmo <= (mem_st && next_state == state) ? tmo + TW'(1) : '0;
            if (state != S_HALT) cycle_cnt <= cycle_cnt + CNT_WID'(1);
            if (retire) retired_cnt <= retired_cnt + CNT_WID'(1);
        end
    end
endmodule

// File: tb/tb_y86_stage_sequencer.sv
// tb_y86_stage_sequencer: randomized instruction streams checked cycle by cycle against a stage-list model
module tb_y86_stage_sequencer;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic [3:0] icode = 4'h0;
    logic imem_ready = 1'b0, imem_error = 1'b0, dmem_ready = 1'b0, dmem_error = 1'b0;
    logic imem_req, dmem_req, f_en, d_en, e_en, m_en, w_en, pc_en, halted;
    logic [1:0] stat;
    logic [31:0] cycle_cnt, retired_cnt;
    int checks = 0;
    int failures = 0;
    logic [31:0] exp_cyc = 0, exp_ret = 0;
    logic [1:0] exp_stat = 0;
    logic exp_halt = 0;
    bit ok;
    y86_stage_sequencer #(.MEM_TIMEOUT(16), .CNT_WID(32)) dut (
        .CLK(CLK), .RST(RST), .icode(icode),
        .imem_ready(imem_ready), .imem_error(imem_error),
        .dmem_ready(dmem_ready), .dmem_error(dmem_error),
        .imem_req(imem_req), .dmem_req(dmem_req),
        .f_en(f_en), .d_en(d_en), .e_en(e_en), .m_en(m_en), .w_en(w_en), .pc_en(pc_en),
        .stat(stat), .halted(halted), .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt)
    );
    always #5 CLK = ~CLK;
    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic step(input logic ir, input logic ie, input logic dr, input logic de,
                        input logic [7:0] ev, input int ri, input logic h, input logic [1:0] hs,
                        input string tag);
        @(negedge CLK);
        RST = 1'b0;
        imem_ready = ir; imem_error = ie; dmem_ready = dr; dmem_error = de;
        #1;
        chk({tag, ".en"}, {imem_req, dmem_req, f_en, d_en, e_en, m_en, w_en, pc_en}, ev);
        chk({tag, ".stat"}, stat, exp_stat);
        chk({tag, ".halted"}, halted, exp_halt);
        chk({tag, ".cycle"}, cycle_cnt, exp_cyc);
        chk({tag, ".retired"}, retired_cnt, exp_ret);
        if (!exp_halt) exp_cyc++;
        exp_ret += 32'(ri);
        if (h) begin
            exp_halt = 1'b1;
            exp_stat = hs;
        end
    endtask
    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            RST = 1'b1;
            imem_ready = 1'b1; imem_error = rb(); dmem_ready = 1'b1; dmem_error = 1'b0;
            #1;
            chk("rst.en", {imem_req, dmem_req, f_en, d_en, e_en, m_en, w_en, pc_en}, 8'h00);
        end
        exp_cyc = 0; exp_ret = 0; exp_stat = 0; exp_halt = 0;
    endtask
    task automatic mem_phase(input bit im, input int dly, input bit err, output bit good);
        logic [7:0] rv, okv;
        int n;
        rv = im ? 8'h80 : 8'h40;
        okv = im ? 8'hA0 : 8'h44;
        n = dly >= 16 ? 16 : dly;
        for (int i = 0; i < n; i++) begin
            if (im) step(1'b0, rb(), rb(), rb(), rv, 0, dly >= 16 && i == 15, 2'd2, "ifwait");
            else step(rb(), rb(), 1'b0, rb(), rv, 0, dly >= 16 && i == 15, 2'd2, "dmwait");
        end
        good = 1'b0;
        if (dly >= 16) return;
        if (im) step(1'b1, err, rb(), rb(), err ? rv : okv, 0, err, 2'd2, "ifrdy");
        else step(rb(), rb(), 1'b1, err, err ? rv : okv, 0, err, 2'd2, "dmrdy");
        good = !err;
    endtask
    task automatic run_instr(input logic [3:0] ic, input int fd, input bit ferr, input int md, input bit merr);
        bit g, is_mem, is_wb;
        icode = ic;
        is_mem = ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
        is_wb = ic inside {4'h2, 4'h3, 4'h6};
        mem_phase(1'b1, fd, ferr, g);
        if (!g) return;
        step(rb(), rb(), rb(), rb(), 8'h10, ic == 0 ? 1 : 0, ic == 0 || ic > 11, ic == 0 ? 2'd1 : 2'd3, "dec");
        if (ic == 0 || ic > 11) return;
        step(rb(), rb(), rb(), rb(), 8'h08, 0, 1'b0, 2'd0, "exe");
        if (is_mem) begin
            mem_phase(1'b0, md, merr, g);
            if (!g) return;
        end
        if (is_mem ? ic != 4'h4 : is_wb) step(rb(), rb(), rb(), rb(), 8'h02, 0, 1'b0, 2'd0, "wb");
        step(rb(), rb(), rb(), rb(), 8'h01, 1, 1'b0, 2'd0, "pc");
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(rb(), rb(), rb(), rb(), 8'h00, 0, 1'b0, 2'd0, "halt");
    endtask
    initial begin
        do_reset(2);
        run_instr(4'h1, 0, 1'b0, 0, 1'b0);
        do_reset(1);
        run_instr(4'h5, 0, 1'b0, 3, 1'b0);
        do_reset(1);
        run_instr(4'hC, 0, 1'b0, 0, 1'b0);
        idle(3);
        do_reset(1);
        run_instr(4'h2, 20, 1'b0, 0, 1'b0);
        idle(3);
        do_reset(1);
        run_instr(4'h0, 1, 1'b0, 0, 1'b0);
        idle(4);
        do_reset(1);
        icode = 4'h5;
        mem_phase(1'b1, 0, 1'b0, ok);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h10, 0, 1'b0, 2'd0, "dec");
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h08, 0, 1'b0, 2'd0, "exe");
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h40, 0, 1'b0, 2'd0, "dmwait");
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h40, 0, 1'b0, 2'd0, "dmwait");
        do_reset(1);
        run_instr(4'h1, 0, 1'b0, 0, 1'b0);
        run_instr(4'h4, 2, 1'b0, 1, 1'b0);
        run_instr(4'h6, 0, 1'b0, 0, 1'b0);
        run_instr(4'h8, 0, 1'b0, 16, 1'b0);
        idle(2);
        do_reset(1);
        for (int n = 0; n < 80; n++) begin
            logic [3:0] ic;
            ic = $urandom_range(0, 3) == 0 ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 11));
            run_instr(ic,
                      $urandom_range(0, 11) == 0 ? 16 + int'($urandom_range(0, 3)) : int'($urandom_range(0, 3)),
                      $urandom_range(0, 15) == 0,
                      $urandom_range(0, 11) == 0 ? 16 + int'($urandom_range(0, 3)) : int'($urandom_range(0, 4)),
                      $urandom_range(0, 15) == 0);
            if (exp_halt) begin
                idle(2);
                do_reset(int'($urandom_range(1, 2)));
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/y86_stage_sequencer.md
Name: y86_stage_sequencer

Overview:
- Multi-cycle control FSM for the Y86 datapath.
- Steps each instruction through fetch, decode, execute, memory, writeback and PC-update.
- Drives one-cycle stage enables, including the PC-update enable that commits the next PC.
- Runs the request/ready handshakes to instruction and data memory, tracks processor status, and keeps cycle and retired-instruction counters.

Parameters:
- MEM_TIMEOUT, 16: cycles to wait for a memory ready before faulting with status ADR.
- CNT_WID, 32: width of the cycle and retired-instruction counters.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset; synchronous, active-high.
- icode  in  4  decoded instruction code; valid from DECODE onward.
- imem_ready  in  1  instruction fetch complete.
- imem_error  in  1  fetch address fault; sampled with imem_ready.
- dmem_ready  in  1  data access complete.
- dmem_error  in  1  data address fault; sampled with dmem_ready.
- imem_req  out  1  fetch request.
- dmem_req  out  1  data access request.
- f_en, d_en, e_en, m_en, w_en, pc_en  out  1 each  stage enables; each is high exactly one cycle per stage.
- stat  out  2  processor status: 0=AOK, 1=HLT, 2=ADR, 3=INS.
- halted  out  1  high in S_HALT.
- cycle_cnt  out  CNT_WID  cycles since reset; frozen once halted.
- retired_cnt  out  CNT_WID  instructions completed.

Behaviour:
- Reset:
  - RST=1 at a clock edge moves the FSM to S_FETCH.
  - All enables, requests and halted go to 0; stat=AOK; both counters and the timeout counter go to 0.
  - RST has priority over every other input, including a ready arriving in the same cycle.
  - A reset mid-access abandons the access; no enable pulses.
- States: S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_PC, S_HALT.
- S_FETCH:
  - imem_req=1 while waiting.
  - On imem_ready=1 with imem_error=0: f_en pulses that cycle, next state S_DECODE.
  - On imem_ready=1 with imem_error=1: stat=ADR, go to S_HALT, no f_en.
  - MEM_TIMEOUT consecutive cycles without ready: stat=ADR, go to S_HALT.
- S_DECODE:
  - d_en=1.
  - icode>0xB: stat=INS, go to S_HALT.
  - icode=0 (HALT): stat=HLT, go to S_HALT. HALT counts as retired, so retired_cnt increments.
  - Otherwise go to S_EXEC.
- S_EXEC:
  - e_en=1.
  - Next state is S_MEM for icode in {4,5,8,9,A,B}.
  - Otherwise next is S_WB for icode in {2,3,6}.
  - Otherwise next is S_PC for icode in {1,7}.
- S_MEM:
  - dmem_req=1 while waiting.
  - Same ready/error/timeout rules as S_FETCH; m_en pulses on a good ready.
  - icode 4 (RMMOVQ) then goes to S_PC; all others go to S_WB.
- S_WB: w_en=1, next state S_PC.
- S_PC: pc_en=1, retired_cnt increments, next state S_FETCH.
- S_HALT:
  - Absorbing; only RST leaves it.
  - All enables and requests are 0; stat holds its fault code; cycle_cnt is frozen.
- Enables are combinational from state and handshake.
- Requests deassert in the cycle after their ready.
- The timeout counter clears on every state entry.
- The minimum instruction is 4 cycles (NOP/JXX with immediate readies). The maximum without stalls is 6 cycles.
- cycle_cnt increments on every non-reset cycle outside S_HALT.
- Both counters wrap modulo 2^CNT_WID silently.
- A memory ready in a non-memory state is ignored.

Test Plan:
- RST high 2 cycles, release, NOP with imem_ready immediate -> f_en, d_en, e_en, pc_en pulse in cycles 1-4; retired_cnt=1; stat=0.
- MRMOVQ (icode 5), imem_ready immediate, dmem_ready after 3 cycles:
  - dmem_req high 4 cycles; m_en pulses once, then w_en, then pc_en.
  - Total 9 cycles; retired_cnt=1.
- icode 0xC fetched -> d_en pulse, then stat=3, halted=1; no e_en; cycle_cnt frozen at 2.
- imem_ready never asserted -> after 16 cycles stat=2, halted=1; imem_req drops to 0.
- HALT (icode 0) -> stat=1, retired_cnt=1, halted; further readies produce no enables.
- RST asserted during S_MEM wait, with dmem_ready high in the same cycle -> no m_en; next cycle is S_FETCH; counters 0; stat=0.
